// File: rtl/icache_burst_controller.sv
// Direct-mapped instruction cache; misses refill a whole line with an in-order burst read.
// Define ICACHE_PERF_CNT_EN to build the saturating HIT_COUNT/MISS_COUNT counters.
module icache_burst_controller #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int INDEX_WIDTH    = 5,
   parameter int WORDS_PER_LINE = 4
`ifdef ICACHE_PERF_CNT_EN
   ,
   parameter int COUNT_WIDTH    = 32
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   CPU_READ,
   input  logic [ADDR_WIDTH-1:0]  CPU_ADDRESS,
   output logic [DATA_WIDTH-1:0]  CPU_INSTR,
   output logic                   CPU_BUSYWAIT,
   input  logic                   FLUSH,
`ifdef ICACHE_PERF_CNT_EN
   output logic [COUNT_WIDTH-1:0] HIT_COUNT,
   output logic [COUNT_WIDTH-1:0] MISS_COUNT,
`endif
   output logic                   MEM_READ_REQ,
   output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
   input  logic                   MEM_BUSYWAIT,
   input  logic [DATA_WIDTH-1:0]  MEM_READDATA,
   input  logic                   MEM_READDATA_VALID
);

   localparam int OFFSET_WIDTH = $clog2(WORDS_PER_LINE);
   localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int LINES        = 1 << INDEX_WIDTH;
   localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(WORDS_PER_LINE - 1);

   localparam logic [1:0] LOOKUP  = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] FILL    = 2'd2;
   localparam logic [1:0] RESPOND = 2'd3;

   typedef struct packed {
      logic [TAG_WIDTH-1:0]    tag;
      logic [INDEX_WIDTH-1:0]  index;
      logic [OFFSET_WIDTH-1:0] offset;
   } addr_t;

   logic [1:0]              state;
   addr_t                   cpu_a, saved_a;
   logic [OFFSET_WIDTH-1:0] beat_cnt;
   logic [LINES-1:0]        valid;
   logic                    flush_pending;

   logic [DATA_WIDTH-1:0]   data_mem [LINES][WORDS_PER_LINE];
   logic [TAG_WIDTH-1:0]    tag_mem  [LINES];

   logic cpu_req, in_lookup, hit, miss, beat_wr, fill_done;

   assign cpu_a     = CPU_ADDRESS;
   // Gate the request with reset so every output sits at its reset value while reset is held.
   assign cpu_req   = CPU_READ && !reset;
   assign in_lookup = (state == LOOKUP);
   assign hit       = in_lookup && cpu_req && !FLUSH && valid[cpu_a.index] &&
                      (tag_mem[cpu_a.index] == cpu_a.tag);
   assign miss      = in_lookup && cpu_req && !hit;
   assign beat_wr   = (state == FILL) && MEM_READDATA_VALID;
   assign fill_done = beat_wr && (beat_cnt == LAST_BEAT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= LOOKUP;
         saved_a       <= '0;
         beat_cnt      <= '0;
         valid         <= '0;
         flush_pending <= 1'b0;
      end else begin
         case (state)
            LOOKUP:
               if (miss) begin
                  saved_a <= cpu_a;
                  state   <= REQ;
               end
            REQ:
               if (!MEM_BUSYWAIT) begin
                  beat_cnt <= '0;
                  state    <= FILL;
               end
            FILL:
               if (MEM_READDATA_VALID) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (fill_done) state <= RESPOND;
               end
            RESPOND: state <= LOOKUP;
            default: state <= LOOKUP;
         endcase

         // A flush on the final beat must win over the line becoming valid.
         if (FLUSH)
            valid <= '0;
         else if (fill_done && !flush_pending)
            valid[saved_a.index] <= 1'b1;

         if (state == RESPOND)
            flush_pending <= 1'b0;
         else if (FLUSH && (state == REQ || state == FILL))
            flush_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (beat_wr)   data_mem[saved_a.index][beat_cnt] <= MEM_READDATA;
      if (fill_done) tag_mem[saved_a.index]            <= saved_a.tag;
   end

   always_comb begin
      CPU_INSTR    = '0;
      CPU_BUSYWAIT = 1'b0;
      MEM_READ_REQ = 1'b0;
      MEM_ADDRESS  = '0;
      case (state)
         LOOKUP: begin
            if (hit) CPU_INSTR = data_mem[cpu_a.index][cpu_a.offset];
            CPU_BUSYWAIT = miss;
         end
         REQ: begin
            MEM_READ_REQ = 1'b1;
            MEM_ADDRESS  = {saved_a.tag, saved_a.index, {OFFSET_WIDTH{1'b0}}};
            CPU_BUSYWAIT = 1'b1;
         end
         FILL:    CPU_BUSYWAIT = 1'b1;
         RESPOND: CPU_INSTR = data_mem[saved_a.index][saved_a.offset];
         default: ;
      endcase
   end

`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         HIT_COUNT  <= '0;
         MISS_COUNT <= '0;
      end else begin
         if (hit && (HIT_COUNT != '1))   HIT_COUNT  <= HIT_COUNT + 1'b1;
         if (miss && (MISS_COUNT != '1)) MISS_COUNT <= MISS_COUNT + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_burst_controller.sv
// Scoreboard bench for icache_burst_controller: fetches queue expected words, a monitor
// checks each delivery, and a memory model checks burst addresses and drives beats.
module tb_icache_burst_controller;

   localparam logic [31:0] NO_MEM = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        CPU_READ;
   logic [31:0] CPU_ADDRESS;
   logic [31:0] CPU_INSTR;
   logic        CPU_BUSYWAIT;
   logic        FLUSH;
   logic        MEM_READ_REQ;
   logic [31:0] MEM_ADDRESS;
   logic        MEM_BUSYWAIT;
   logic [31:0] MEM_READDATA;
   logic        MEM_READDATA_VALID;
`ifdef ICACHE_PERF_CNT_EN
   logic [1:0]  HIT_COUNT, MISS_COUNT;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      int          stall;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          acc_stall = 0;
   int          gap_at    = -1;

   icache_burst_controller #(
`ifdef ICACHE_PERF_CNT_EN
      .COUNT_WIDTH(2),
`endif
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .INDEX_WIDTH(5), .WORDS_PER_LINE(4)
   ) dut (
      .clk(clk), .reset(reset),
      .CPU_READ(CPU_READ), .CPU_ADDRESS(CPU_ADDRESS), .CPU_INSTR(CPU_INSTR),
      .CPU_BUSYWAIT(CPU_BUSYWAIT), .FLUSH(FLUSH),
`ifdef ICACHE_PERF_CNT_EN
      .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT),
`endif
      .MEM_READ_REQ(MEM_READ_REQ), .MEM_ADDRESS(MEM_ADDRESS), .MEM_BUSYWAIT(MEM_BUSYWAIT),
      .MEM_READDATA(MEM_READDATA), .MEM_READDATA_VALID(MEM_READDATA_VALID)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_instr"},   CPU_INSTR, 32'h0);
      check({tag, "_busy"},    {31'b0, CPU_BUSYWAIT}, 32'h0);
      check({tag, "_memreq"},  {31'b0, MEM_READ_REQ}, 32'h0);
      check({tag, "_memaddr"}, MEM_ADDRESS, 32'h0);
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that ends the delivery cycle.
   task automatic fetch(input logic [31:0] a, input logic [31:0] instr, input int stall,
                        input logic [31:0] line, input int acc, input int gap, input int flush_cyc);
      int cyc;
      bit done;
      acc_stall = acc;
      gap_at    = gap;
      exp_q.push_back('{a, instr, stall});
      if (line != NO_MEM) mem_q.push_back(line);
      CPU_ADDRESS = a;
      CPU_READ    = 1'b1;
      FLUSH       = (flush_cyc == 0);
      cyc = 0;
      forever begin
         @(negedge clk);
         done = !CPU_BUSYWAIT;
         @(posedge clk);
         #1;
         cyc++;
         if (done) break;
         if (cyc > 40) begin
            fail_now($sformatf("fetch_timeout addr 0x%0h", a));
            break;
         end
         FLUSH = (cyc == flush_cyc);
      end
      FLUSH    = 1'b0;
      CPU_READ = 1'b0;
   endtask

   // Monitor: every cycle the CPU sees BUSYWAIT low with a read pending is one delivery.
   initial begin : monitor
      int   stall_cnt;
      exp_t e;
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) stall_cnt = 0;
         else if (!CPU_READ) begin
            stall_cnt = 0;
            check("idle_instr", CPU_INSTR, 32'h0);
            check("idle_busy", {31'b0, CPU_BUSYWAIT}, 32'h0);
         end else if (CPU_BUSYWAIT) stall_cnt++;
         else if (exp_q.size() == 0) fail_now($sformatf("unexpected_response addr 0x%0h", CPU_ADDRESS));
         else begin
            e = exp_q.pop_front();
            check($sformatf("instr@0x%0h", e.addr), CPU_INSTR, e.instr);
            check($sformatf("stall@0x%0h", e.addr), stall_cnt, e.stall);
            stall_cnt = 0;
         end
      end
   end

   // Memory model: word at address a holds a + 0x60; junk strobes outside FILL must be ignored.
   initial begin : memory
      bit          busy, filling, gap_done;
      int          beat, req_cycles;
      logic [31:0] base;
      busy = 0; filling = 0; gap_done = 0; beat = 0; req_cycles = 0; base = '0;
      MEM_BUSYWAIT = 1'b0; MEM_READDATA_VALID = 1'b0; MEM_READDATA = '0;
      forever begin
         @(negedge clk);
         MEM_READDATA_VALID = 1'b0;
         MEM_BUSYWAIT       = 1'b0;
         if (reset) busy = 0;
         else if (MEM_READ_REQ) begin
            if (!busy) begin
               busy = 1; filling = 0; gap_done = 0; beat = 0; req_cycles = 0;
               base = MEM_ADDRESS;
               if (mem_q.size() == 0) fail_now($sformatf("unexpected_mem_req 0x%0h", MEM_ADDRESS));
               else check("mem_addr", MEM_ADDRESS, mem_q.pop_front());
            end else check("mem_addr_stable", MEM_ADDRESS, base);
            MEM_BUSYWAIT       = (req_cycles < acc_stall);
            MEM_READDATA_VALID = 1'b1;
            MEM_READDATA       = 32'hDEAD_BEEF;
            req_cycles++;
         end else if (busy) begin
            if (!filling) begin
               filling = 1;
               check("req_cycles", req_cycles, acc_stall + 1);
            end
            if (beat == gap_at && !gap_done) gap_done = 1;
            else begin
               MEM_READDATA_VALID = 1'b1;
               MEM_READDATA       = base + beat + 32'h60;
               beat++;
               if (beat == 4) busy = 0;
            end
         end else begin
            MEM_READDATA_VALID = 1'b1;
            MEM_READDATA       = 32'hDEAD_BEEF;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      reset = 1'b1; CPU_READ = 1'b0; CPU_ADDRESS = '0; FLUSH = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
`ifdef ICACHE_PERF_CNT_EN
      check("reset_hit_count", HIT_COUNT, 32'h0);
      check("reset_miss_count", MISS_COUNT, 32'h0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;

      // cold miss, then hits in the same line
      fetch(32'h42, 32'hA2, 6, 32'h40, 0, -1, -1);
      fetch(32'h43, 32'hA3, 0, NO_MEM, 0, -1, -1);
      fetch(32'h40, 32'hA0, 0, NO_MEM, 0, -1, -1);
      fetch(32'h41, 32'hA1, 0, NO_MEM, 0, -1, -1);
`ifdef ICACHE_PERF_CNT_EN
      check("hit_count_3", HIT_COUNT, 32'h3);
      check("miss_count_1", MISS_COUNT, 32'h1);
`endif
      fetch(32'h42, 32'hA2, 0, NO_MEM, 0, -1, -1);
      fetch(32'h43, 32'hA3, 0, NO_MEM, 0, -1, -1);
`ifdef ICACHE_PERF_CNT_EN
      check("hit_count_sat", HIT_COUNT, 32'h3);
      check("miss_count_hold", MISS_COUNT, 32'h1);
`endif

      // conflict miss with one beat gap, then the evicted line misses
      fetch(32'hC2, 32'h122, 7, 32'hC0, 0, 2, -1);
      fetch(32'h42, 32'hA2, 6, 32'h40, 0, -1, -1);

      // memory holds off acceptance for three cycles
      fetch(32'h85, 32'hE5, 9, 32'h84, 3, -1, -1);

      // flush while idle invalidates the line
      FLUSH = 1'b1;
      @(posedge clk); #1;
      FLUSH = 1'b0;
      fetch(32'h41, 32'hA1, 6, 32'h40, 0, -1, -1);

      // flush on beat 2: word still delivered, line left invalid
      fetch(32'h106, 32'h166, 6, 32'h104, 0, -1, 4);
      fetch(32'h107, 32'h167, 6, 32'h104, 0, -1, -1);
      // flush together with a read in LOOKUP forces a miss but the refill stays valid
      fetch(32'h105, 32'h165, 6, 32'h104, 0, -1, 0);
      fetch(32'h104, 32'h164, 0, NO_MEM, 0, -1, -1);

      // reset after two beats of a fill
      acc_stall = 0; gap_at = -1;
      mem_q.push_back(32'h40);
      CPU_ADDRESS = 32'h42;
      CPU_READ    = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      reset    = 1'b1;
      CPU_READ = 1'b0;
      @(negedge clk);
      check_reset_outputs("midfill_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      fetch(32'h42, 32'hA2, 6, 32'h40, 0, -1, -1);
      fetch(32'h43, 32'hA3, 0, NO_MEM, 0, -1, -1);

      repeat (3) @(posedge clk);
      check("pending_responses", exp_q.size(), 32'h0);
      check("pending_mem_reqs", mem_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_burst_controller.md
# icache_burst_controller

Direct-mapped instruction cache with internal tag, valid and data arrays. Lines are multi-word and refilled by a burst read. Hits are served with zero added latency. A global flush input invalidates all lines. It sits between the CPU fetch port and the instruction-memory read port.

## Interface
- `ADDR_WIDTH`, 32: word-address width (addresses are word addresses).
- `DATA_WIDTH`, 32: instruction word width.
- `INDEX_WIDTH`, 5: line index bits; 2^INDEX_WIDTH lines.
- `WORDS_PER_LINE`, 4: words per line; a power of 2, ≥2.
  - OFFSET_WIDTH = log2(WORDS_PER_LINE).
  - TAG_WIDTH = ADDR_WIDTH − INDEX_WIDTH − OFFSET_WIDTH.
- `COUNT_WIDTH`, 32: performance-counter width. Used only when `ICACHE_PERF_CNT_EN` is defined.
- Address split: offset = `addr[OFFSET_WIDTH-1:0]`, index = next INDEX_WIDTH bits, tag = upper bits.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `CPU_READ` in 1: fetch request.
- `CPU_ADDRESS` in ADDR_WIDTH: fetch word address.
- `CPU_INSTR` out DATA_WIDTH: fetched instruction.
- `CPU_BUSYWAIT` out 1: stall.
- `FLUSH` in 1: invalidate all lines.
- `MEM_READ_REQ` out 1: burst request.
- `MEM_ADDRESS` out ADDR_WIDTH: line-aligned burst address (offset bits 0).
- `MEM_BUSYWAIT` in 1: memory not yet accepting.
- `MEM_READDATA` in DATA_WIDTH: beat data.
- `MEM_READDATA_VALID` in 1: beat strobe. Beats arrive in order, offset 0 first.
- `HIT_COUNT` out COUNT_WIDTH: present only when `ICACHE_PERF_CNT_EN` is defined.
- `MISS_COUNT` out COUNT_WIDTH: present only when `ICACHE_PERF_CNT_EN` is defined.

## Operation
- States:
  - LOOKUP (reset state)
  - REQ
  - FILL
  - RESPOND
- **LOOKUP**
  - On hit (`CPU_READ`, valid[index], tag match, `FLUSH`=0):
    - CPU_INSTR = data[index][offset], CPU_BUSYWAIT = 0, combinationally.
    - Stay in LOOKUP.
  - On miss (`CPU_READ` and not hit; `FLUSH`=1 forces a miss):
    - CPU_BUSYWAIT = 1 combinationally.
    - Latch CPU_ADDRESS into saved_addr.
    - Go to REQ.
  - If `CPU_READ`=0: CPU_BUSYWAIT = 0, CPU_INSTR = 0.
- **REQ**
  - MEM_READ_REQ = 1, MEM_ADDRESS = {saved tag, saved index, 0}, CPU_BUSYWAIT = 1.
  - Go to FILL on the first cycle with `MEM_BUSYWAIT`=0; otherwise hold with the address stable.
- **FILL**
  - CPU_BUSYWAIT = 1.
  - Each cycle with `MEM_READDATA_VALID`=1: write the beat to data[saved index][beat_cnt], then increment beat_cnt (OFFSET_WIDTH bits, cleared on entry).
  - On the beat with beat_cnt = WORDS_PER_LINE−1:
    - Write the tag.
    - Set valid, unless flush_pending.
    - Go to RESPOND.
- **RESPOND**
  - CPU_BUSYWAIT = 0, CPU_INSTR = data[saved index][saved offset].
  - Clear flush_pending.
  - Go to LOOKUP next cycle.
- `MEM_READDATA_VALID` outside FILL is ignored.
- **Flush**
  - `FLUSH`=1 in any state clears all valid bits at the next edge.
  - If asserted in REQ or FILL, it also sets flush_pending. The in-flight fill completes and returns data to the CPU, but the line stays invalid.
- **Stability:** the CPU holds `CPU_ADDRESS`/`CPU_READ` while stalled. The controller uses only saved_addr after the miss cycle.
- **Reset values**
  - Outputs: CPU_INSTR 0, CPU_BUSYWAIT 0, MEM_READ_REQ 0, MEM_ADDRESS 0.
  - Internal: all valid bits 0, beat_cnt 0, flush_pending 0, counters 0.
  - Tag/data arrays are not reset.
- **Reset mid-fill:** returns to LOOKUP. The partially filled line stays invalid.

## Timing
- Hit: 0-cycle latency; data valid in the same cycle as `CPU_READ`.
- Minimum miss (memory accepts immediately, back-to-back beats):
  - Cycle 0: LOOKUP, BUSYWAIT=1.
  - Cycle 1: REQ.
  - Cycles 2 to W+1: beats.
  - Cycle W+2: RESPOND with data, BUSYWAIT=0.
  - Stall is W+2 cycles (6 for W=4).
- Each extra MEM_BUSYWAIT cycle or beat gap adds exactly one stall cycle.
- Array writes take effect at the clock edge of the beat. The RESPOND read sees the final line.

## Configuration
- `ICACHE_PERF_CNT_EN` defined:
  - HIT_COUNT increments on each LOOKUP hit cycle.
  - MISS_COUNT increments on each LOOKUP→REQ transition.
  - Both saturate at all-ones and clear on reset.
- `ICACHE_PERF_CNT_EN` not defined: no counters and no `HIT_COUNT`/`MISS_COUNT` ports.

## Test plan
All scenarios use defaults (W=4, INDEX_WIDTH=5).
1. **Cold miss.** Read 0x42; memory returns 0xA0,0xA1,0xA2,0xA3.
   - Required: MEM_ADDRESS=0x40 while MEM_READ_REQ=1; BUSYWAIT high for 6 cycles; RESPOND CPU_INSTR=0xA2.
   - Then: read 0x43 hits with 0xA3 in the same cycle.
2. **Conflict miss.** After scenario 1, read 0xC2 (same index, tag differs).
   - Required: miss, MEM_ADDRESS=0xC0, refill.
   - Then: read 0x42 misses again.
3. **Accept stall.** MEM_BUSYWAIT held high 3 cycles during REQ.
   - Required: MEM_READ_REQ and MEM_ADDRESS stable for 4 cycles; stall = 9 cycles.
4. **Flush.**
   - Flush after a fill: pulse FLUSH, then read 0x41 → miss.
   - Flush mid-FILL (beat 2): CPU receives the correct word in RESPOND; next read of the same line misses.
5. **Reset mid-FILL.** Assert reset after 2 beats.
   - Required: outputs at reset values; next read of that line misses and reissues MEM_ADDRESS=0x40.
6. **Counters (`ICACHE_PERF_CNT_EN`).** Scenario 1 followed by 3 hits.
   - Required: HIT_COUNT=3, MISS_COUNT=1.
   - Saturation check with COUNT_WIDTH=2: after 5 hits, HIT_COUNT holds at 3.
